modport_counter: RTL and testbench



---
 rtl/modport_pkg.sv | 18 +
 rtl/modport_step_cmp.sv | 38 +++
 rtl/modport_counter.sv | 70 +++++++
 tb/tb_modport_counter.sv | 119 +++++++++++
 4 files changed

// File: rtl/modport_pkg.sv
// Shared types and result encodings for the sample-stream step checker.
package modport_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam int unsigned INCR_BIT = 2;
   localparam int unsigned DECR_BIT = 1;
   localparam int unsigned ERR_BIT  = 0;

   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_INCR = 3'b100;
   localparam logic [2:0] RES_DECR = 3'b010;
   localparam logic [2:0] RES_ERR  = 3'b001;

endpackage

// File: rtl/modport_step_cmp.sv
// Combinational step classifier: compares a new sample against the held reference.
module modport_step_cmp
   import modport_pkg::*;
#(
   parameter int unsigned MAX_VAL = 15,
   parameter bit          WRAP_EN = 1'b0
) (
   input  logic [3:0] prev,
   input  logic [3:0] in,
   output logic [2:0] res
);

   localparam logic [4:0] MAX5 = 5'(MAX_VAL);

   logic [4:0] prev5;
   logic [4:0] in5;

   // 5-bit operands keep prev+1 from wrapping back onto 0
   assign prev5 = {1'b0, prev};
   assign in5   = {1'b0, in};

   always_comb begin
      res = RES_ERR;
      if (in5 > MAX5)
         res = RES_ERR;
      else if ((prev5 < MAX5) && (in5 == prev5 + 5'd1))
         res = RES_INCR;
      else if ((prev5 > 5'd0) && (in5 == prev5 - 5'd1))
         res = RES_DECR;
      else if (WRAP_EN && (prev5 == MAX5) && (in5 == 5'd0))
         res = RES_INCR;
      else if (WRAP_EN && (prev5 == 5'd0) && (in5 == MAX5))
         res = RES_DECR;
      else if (in5 == prev5)
         res = RES_NONE;
   end

endmodule

// File: rtl/modport_counter.sv
// Sample-stream step checker: flags +1 / -1 / illegal jumps one cycle after each valid sample.
module modport_counter
   import modport_pkg::*;
#(
   parameter int unsigned MAX_VAL = 15,
   parameter bit          WRAP_EN = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in,
   input  logic       valid,
   output logic [2:0] incr_decr_error
);

   localparam logic [4:0] MAX5 = 5'(MAX_VAL);

   state_t     state, state_nxt;
   logic [3:0] prev, prev_nxt;
   logic [2:0] flags_nxt;
   logic [2:0] cmp_res;
   logic       legal;

   modport_step_cmp #(
      .MAX_VAL (MAX_VAL),
      .WRAP_EN (WRAP_EN)
   ) u_cmp (
      .prev (prev),
      .in   (in),
      .res  (cmp_res)
   );

   assign legal = ({1'b0, in} <= MAX5);

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      flags_nxt = RES_NONE;
      if (valid) begin
         case (state)
            EMPTY: begin
               if (legal) begin
                  prev_nxt  = in;
                  state_nxt = TRACK;
               end else begin
                  flags_nxt = RES_ERR;
               end
            end
            TRACK: begin
               flags_nxt = cmp_res;
               if (legal)
                  prev_nxt = in;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= EMPTY;
         prev            <= '0;
         incr_decr_error <= RES_NONE;
      end else begin
         state           <= state_nxt;
         prev            <= prev_nxt;
         incr_decr_error <= flags_nxt;
      end
   end

endmodule

// File: tb/tb_modport_counter.sv
// Scoreboard bench for modport_counter across three parameterisations.
module tb_modport_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
   logic       val0 = 1'b0, val1 = 1'b0, val2 = 1'b0;
   logic [3:0] in0  = '0,   in1  = '0,   in2  = '0;
   logic [2:0] out0, out1, out2;

   logic [2:0] q0[$];
   logic [2:0] q1[$];
   logic [2:0] q2[$];
   string      n0[$];
   string      n1[$];
   string      n2[$];

   int unsigned checks = 0;
   int unsigned fails  = 0;

   // u0: default, u1: wrap enabled, u2: reduced range
   modport_counter #(.MAX_VAL(15), .WRAP_EN(1'b0)) u0 (
      .clk(clk), .rst(rst0), .in(in0), .valid(val0), .incr_decr_error(out0));
   modport_counter #(.MAX_VAL(15), .WRAP_EN(1'b1)) u1 (
      .clk(clk), .rst(rst1), .in(in1), .valid(val1), .incr_decr_error(out1));
   modport_counter #(.MAX_VAL(9), .WRAP_EN(1'b0)) u2 (
      .clk(clk), .rst(rst2), .in(in2), .valid(val2), .incr_decr_error(out2));

   task automatic step(input int k, input logic r, input logic v,
                       input logic [3:0] x, input logic [2:0] exp, input string name);
      @(negedge clk);
      case (k)
         0: begin rst0 = r; val0 = v; in0 = x; q0.push_back(exp); n0.push_back(name); end
         1: begin rst1 = r; val1 = v; in1 = x; q1.push_back(exp); n1.push_back(name); end
         default: begin rst2 = r; val2 = v; in2 = x; q2.push_back(exp); n2.push_back(name); end
      endcase
   endtask

   task automatic cmp(input logic [2:0] act, input logic [2:0] exp, input string name);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Monitor: each popped entry describes the output registered on the preceding edge
   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) cmp(out0, q0.pop_front(), n0.pop_front());
      if (q1.size() > 0) cmp(out1, q1.pop_front(), n1.pop_front());
      if (q2.size() > 0) cmp(out2, q2.pop_front(), n2.pop_front());
   end

   initial begin
      // u0: MAX 15, no wrap
      step(0, 1, 0, 4'd0,  3'b000, "u0 reset");
      step(0, 0, 1, 4'd3,  3'b000, "u0 first ref 3");
      step(0, 0, 1, 4'd4,  3'b100, "u0 3->4");
      step(0, 0, 1, 4'd5,  3'b100, "u0 4->5");
      step(0, 0, 0, 4'd9,  3'b000, "u0 idle");
      step(0, 0, 1, 4'd6,  3'b100, "u0 5->6 after idle");
      step(0, 1, 0, 4'd0,  3'b000, "u0 reset2");
      step(0, 0, 1, 4'd8,  3'b000, "u0 ref 8");
      step(0, 0, 1, 4'd7,  3'b010, "u0 8->7");
      step(0, 0, 1, 4'd7,  3'b000, "u0 7 hold");
      step(0, 0, 1, 4'd6,  3'b010, "u0 7->6");
      step(0, 1, 0, 4'd0,  3'b000, "u0 reset3");
      step(0, 0, 1, 4'd2,  3'b000, "u0 ref 2");
      step(0, 0, 1, 4'd9,  3'b001, "u0 2->9 jump");
      step(0, 0, 1, 4'd10, 3'b100, "u0 9->10");
      step(0, 1, 0, 4'd0,  3'b000, "u0 reset4");
      step(0, 0, 1, 4'd15, 3'b000, "u0 ref 15");
      step(0, 0, 1, 4'd0,  3'b001, "u0 15->0 no wrap");
      step(0, 0, 1, 4'd15, 3'b001, "u0 0->15 no wrap");
      step(0, 1, 0, 4'd0,  3'b000, "u0 reset5");
      step(0, 0, 1, 4'd5,  3'b000, "u0 ref 5");
      step(0, 1, 1, 4'd6,  3'b000, "u0 rst mid-stream");
      step(0, 0, 1, 4'd6,  3'b000, "u0 6 first after rst");
      step(0, 0, 1, 4'd7,  3'b100, "u0 6->7");
      step(0, 0, 0, 4'd0,  3'b000, "u0 tail idle");

      // u1: MAX 15, wrap enabled
      step(1, 1, 0, 4'd0,  3'b000, "u1 reset");
      step(1, 0, 1, 4'd15, 3'b000, "u1 ref 15");
      step(1, 0, 1, 4'd0,  3'b100, "u1 15->0 wrap");
      step(1, 0, 1, 4'd15, 3'b010, "u1 0->15 wrap");
      step(1, 0, 1, 4'd14, 3'b010, "u1 15->14");
      step(1, 0, 1, 4'd15, 3'b100, "u1 14->15");
      step(1, 0, 1, 4'd1,  3'b001, "u1 15->1");
      step(1, 0, 0, 4'd0,  3'b000, "u1 tail idle");

      // u2: MAX 9, no wrap
      step(2, 1, 0, 4'd0,  3'b000, "u2 reset");
      step(2, 0, 1, 4'd12, 3'b001, "u2 12 while empty");
      step(2, 0, 1, 4'd3,  3'b000, "u2 ref 3");
      step(2, 0, 1, 4'd12, 3'b001, "u2 12 out of range");
      step(2, 0, 1, 4'd4,  3'b100, "u2 3->4 prev kept");
      step(2, 0, 1, 4'd9,  3'b001, "u2 4->9 jump");
      step(2, 0, 1, 4'd8,  3'b010, "u2 9->8");
      step(2, 0, 1, 4'd9,  3'b100, "u2 8->9");
      step(2, 0, 1, 4'd10, 3'b001, "u2 10 above max");
      step(2, 0, 1, 4'd0,  3'b001, "u2 9->0 no wrap");
      step(2, 0, 1, 4'd13, 3'b001, "u2 13 above max");
      step(2, 0, 1, 4'd1,  3'b100, "u2 0->1");
      step(2, 0, 0, 4'd0,  3'b000, "u2 tail idle");

      repeat (3) @(negedge clk);
      checks++;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
